cmp_unit_iter: RTL
==================

# cmp_unit_iter

Iterative, parametrised successor to the branch comparator. It evaluates the six RISC-V branch conditions (BEQ, BNE, BLT, BGE, BLTU, BGEU) on WIDTH-bit operands by scanning CHUNK bits per cycle, MSB chunk first, and stops as soon as a chunk differs. It sits between operand fetch and the branch-resolve stage of multi-cycle cores, behind a valid/ready handshake on both sides, so the core can trade comparator area for latency.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; N = WIDTH/CHUNK chunks. CHUNK = WIDTH gives single-chunk operation.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block accepts a request; equals (state==IDLE) && !rst.
- i_op  input  `CMPOP_WIDTH  operation; uses the `CMPOP_*` codes from cmp_unit.vh.
- i_a, i_b  input  WIDTH  operands (rs1, rs2).
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_taken  output  1  branch condition result; 0 whenever o_valid=0.

## Operation
- Request transfer: i_valid && o_ready at a rising edge. Latch i_op, i_a and i_b. Set chunk index idx = N-1. Go to RUN.
- States:
  - IDLE: o_ready=1. Changes to i_op, i_a and i_b are ignored.
  - RUN: compare chunk idx of the latched operands.
  - DONE: o_valid=1.
- RUN step, one per cycle:
  - Chunks differ: record eq=0 and lt = (a_chunk < b_chunk). Go to DONE.
  - Chunks equal and idx==0: record eq=1 and lt=0. Go to DONE.
  - Chunks equal otherwise: idx decrements and the state stays RUN.
- Signedness:
  - For BLT/BGE, the top chunk (idx = N-1) is compared two's-complement signed. Invert its MSB on both operands, then compare unsigned.
  - All other chunks, and every chunk for BLTU/BGEU, are compared unsigned.
  - BEQ/BNE still scan; only eq is used.
- Result in DONE:
  - BEQ = eq; BNE = !eq.
  - BLT and BLTU = lt; BGE and BGEU = !lt.
  - Any unrecognised op gives 0.
  - o_taken is held stable for the whole of DONE.
- Result transfer: o_valid && i_ready at an edge. Go to IDLE; o_valid drops after that edge.
- One request is outstanding at a time. No request is accepted in the same cycle a result is consumed.
- Reset (rst=1 at an edge) from any state:
  - Go to IDLE. Clear eq, lt and idx.
  - An in-flight compare is discarded and produces no o_valid.
  - While rst=1: o_valid=0, o_taken=0, o_ready=0.
  - After reset: o_ready=1, o_valid=0, o_taken=0.

## Timing
- Latency: let the accept edge be E0. o_valid rises after edge E0+m, where m = N - k and k is the index of the first differing chunk (k=0 if none differ).
- Range of m is 1 to N. Fully equal operands always cost N cycles.
- Outputs:
  - o_valid and o_taken are registered (state-decoded), with no combinational path from i_a or i_b.
  - o_ready is decoded from state and rst only.
- o_valid stays high until a cycle where i_ready=1. A stalled DONE holds indefinitely.
- Minimum request-to-request spacing is m+2 edges (accept, m RUN cycles, result transfer).
- i_ready is ignored outside DONE. i_valid is ignored outside IDLE.

## Test plan
Bench uses WIDTH=32, CHUNK=8, so N=4.
- **Reset:** rst=1 for 2 cycles with i_valid=1 -> o_valid=0, o_taken=0, o_ready=0 throughout. After release, o_ready=1 and no result appears.
- **Full scan:**
  - BEQ 3,3 -> o_valid 4 cycles after accept, o_taken=1.
  - BNE 3,3 -> latency 4, o_taken=0.
  - BGEU 0,0 -> latency 4, o_taken=1.
- **Early exit:**
  - BLTU 0x01000000, 0x00FFFFFF -> latency 1, o_taken=0.
  - BLT -33 (0xFFFFFFDF), -22 (0xFFFFFFEA) -> latency 4, o_taken=1.
  - BGE 0x00001000, 0x00000FFF -> latency 3, o_taken=1.
- **Signed top chunk:**
  - -22 vs 33: BLT -> 1, BLTU -> 0, BGE -> 0, BGEU -> 1; each with latency 1.
  - 33 vs -22: BLT -> 0, BGEU -> 0.
- **Backpressure:** hold i_ready=0 for 5 cycles after o_valid rises. o_valid and o_taken stay stable, o_ready=0, and a new i_valid pulse is ignored. Then set i_ready=1: o_valid falls after that edge, o_ready=1, and the next request is accepted normally.
- **Reset mid-RUN:** start BEQ 5,5 and assert rst for 1 cycle at RUN cycle 2. No o_valid follows, and o_ready=1 after release. A new BNE 5,6 gives o_taken=1 with latency 4.

Source files
------------

// File: rtl/cmp_unit_iter.sv
// Iterative branch comparator: scans CHUNK bits per cycle, MSB chunk first,
// and resolves the six RISC-V branch conditions behind valid/ready handshakes.

`ifndef CMPOP_WIDTH
`define CMPOP_WIDTH 3
`endif
`ifndef CMPOP_BEQ
`define CMPOP_BEQ  3'd0
`endif
`ifndef CMPOP_BNE
`define CMPOP_BNE  3'd1
`endif
`ifndef CMPOP_BLT
`define CMPOP_BLT  3'd2
`endif
`ifndef CMPOP_BGE
`define CMPOP_BGE  3'd3
`endif
`ifndef CMPOP_BLTU
`define CMPOP_BLTU 3'd4
`endif
`ifndef CMPOP_BGEU
`define CMPOP_BGEU 3'd5
`endif

module cmp_unit_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [`CMPOP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]        i_a,
  input  logic [WIDTH-1:0]        i_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_taken
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [`CMPOP_WIDTH-1:0]     op;
    logic [N-1:0][CHUNK-1:0]     a;
    logic [N-1:0][CHUNK-1:0]     b;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q;
  logic [IW-1:0] idx_q;
  logic          eq_q, lt_q;

  logic [CHUNK-1:0] a_c, b_c;
  logic             signed_top, chunk_ne, chunk_lt, last_chunk, res;

  // Signed compare on the top chunk: flipping the sign bit maps two's
  // complement order onto unsigned order.
  always_comb begin
    a_c        = req_q.a[idx_q];
    b_c        = req_q.b[idx_q];
    signed_top = ((req_q.op == `CMPOP_BLT) || (req_q.op == `CMPOP_BGE)) &&
                 (idx_q == IW'(N-1));
    if (signed_top) begin
      a_c[CHUNK-1] = ~a_c[CHUNK-1];
      b_c[CHUNK-1] = ~b_c[CHUNK-1];
    end
    chunk_ne   = (a_c != b_c);
    chunk_lt   = (a_c < b_c);
    last_chunk = (idx_q == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)                 state_d = RUN;
      RUN:     if (chunk_ne || last_chunk)  state_d = DONE;
      DONE:    if (i_ready)                 state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_valid) begin
        req_q <= {i_op, i_a, i_b};
        idx_q <= IW'(N-1);
      end
      if (state_q == RUN) begin
        if (chunk_ne) begin
          eq_q <= 1'b0;
          lt_q <= chunk_lt;
        end else if (last_chunk) begin
          eq_q <= 1'b1;
          lt_q <= 1'b0;
        end else begin
          idx_q <= idx_q - IW'(1);
        end
      end
    end
  end

  always_comb begin
    res = 1'b0;
    case (req_q.op)
      `CMPOP_BEQ:              res = eq_q;
      `CMPOP_BNE:              res = ~eq_q;
      `CMPOP_BLT, `CMPOP_BLTU: res = lt_q;
      `CMPOP_BGE, `CMPOP_BGEU: res = ~lt_q;
      default:                 res = 1'b0;
    endcase
  end

  // Outputs decode only registered state (plus rst), never the operands.
  assign o_ready = (state_q == IDLE) && !rst;
  assign o_valid = (state_q == DONE) && !rst;
  assign o_taken = o_valid && res;

endmodule
